// File: rtl/bias_pkg.sv
// Shared definitions for the ping-pong bias SRAM writer: FSM encoding,
// default geometry and a small arithmetic helper.
package bias_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        WAIT_RD = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int BIAS_W_DEF = 32;
    localparam int LANES      = 2;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/biassram_wr_pp_if.sv
// FIFO-side and SRAM-side bus of the bias writer. master = the writer,
// slave = the FIFO/SRAM environment.
interface biassram_wr_pp_if #(
    parameter int DIN_W     = 64,
    parameter int BIAS_W    = 32,
    parameter int ADDR_BITS = 9
);
    logic [DIN_W-1:0]       fifo_data;
    logic                   fifo_empty_n;
    logic                   fifo_read;
    logic [1:0]             cen_bias;
    logic [1:0]             wen_bias;
    logic [2*ADDR_BITS-1:0] addr_bias;
    logic [2*BIAS_W-1:0]    din_bias;

    modport master (
        input  fifo_data, fifo_empty_n,
        output fifo_read, cen_bias, wen_bias, addr_bias, din_bias
    );

    modport slave (
        output fifo_data, fifo_empty_n,
        input  fifo_read, cen_bias, wen_bias, addr_bias, din_bias
    );
endinterface

// File: rtl/bias_unpack.sv
// Beat-to-lane unpacker: one holding register fed from a FWFT FIFO, emitting
// one BIAS_W lane per cycle while it holds valid data.
module bias_unpack #(
    parameter int DIN_W    = 64,
    parameter int BIAS_W   = 32,
    parameter int LEN_BITS = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,        // latch beat budget for a new layer
    input  logic [LEN_BITS-1:0] beats,
    input  logic                active,      // writer is in LOAD
    input  logic                flush,       // last bias of layer written this cycle
    input  logic [DIN_W-1:0]    fifo_data,
    input  logic                fifo_empty_n,
    output logic                fifo_read,
    output logic [BIAS_W-1:0]   lane_data,
    output logic                lane_valid
);
    localparam int N_LANES = DIN_W / BIAS_W;
    localparam int LANE_W  = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    logic [DIN_W-1:0]    hold;
    logic                hold_valid;
    logic [LANE_W-1:0]   lane;
    logic [LEN_BITS-1:0] beats_left;
    logic                last_lane;
    logic                pop;

    assign last_lane  = hold_valid && (lane == LANE_W'(N_LANES - 1));
    assign fifo_read  = active && (beats_left != '0) && (!hold_valid || last_lane);
    assign pop        = fifo_read && fifo_empty_n;
    assign lane_valid = hold_valid;
    assign lane_data  = hold[int'(lane) * BIAS_W +: BIAS_W];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid <= 1'b0;
            lane       <= '0;
            beats_left <= '0;
        end else begin
            if (load)
                beats_left <= beats;
            else if (pop)
                beats_left <= beats_left - LEN_BITS'(1);

            if (pop) begin
                hold_valid <= 1'b1;
                lane       <= '0;
            end else if (hold_valid) begin
                if (flush || last_lane)
                    hold_valid <= 1'b0;
                else
                    lane <= lane + LANE_W'(1);
            end
        end
    end

    // NOTE: the data register has no reset; hold_valid alone qualifies it.
    always_ff @(posedge clk) begin
        if (pop)
            hold <= fifo_data;
    end

endmodule

// File: rtl/biassram_wr_pp.sv
// Ping-pong bias SRAM writer: loads one layer of biases into bank wr_bank,
// then hands the bank to the first-read block and flips banks.
module biassram_wr_pp
    import bias_pkg::*;
#(
    parameter int DIN_W     = LANES * BIAS_W_DEF,
    parameter int BIAS_W    = BIAS_W_DEF,
    parameter int ADDR_BITS = 9,
    parameter int LEN_BITS  = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [LEN_BITS-1:0] bias_len,
    biassram_wr_pp_if.master    bus,
    output logic                wr_bank,
    output logic                rd_bank,
    output logic                rd1st_start,
    input  logic                rd1st_busy,
    input  logic                rd1st_done,
    output logic                busy,
    output logic                done,
    output logic                err_len
);
    localparam int                  N_LANES = DIN_W / BIAS_W;
    localparam logic [LEN_BITS-1:0] DEPTH   = LEN_BITS'(2 ** ADDR_BITS);

    state_t              state, state_n;
    logic [LEN_BITS-1:0] len_q;
    logic [ADDR_BITS:0]  wr_cnt;
    logic                started;
    logic                len_ok, accept, wr_en, last_wr;
    logic                lane_valid;
    logic [BIAS_W-1:0]   lane_data;
    logic [LEN_BITS-1:0] beats;

    assign len_ok  = (bias_len != '0) && (bias_len <= DEPTH);
    assign accept  = (state == IDLE) && start && len_ok;
    assign wr_en   = (state == LOAD) && lane_valid;
    assign last_wr = wr_en && (LEN_BITS'(wr_cnt) == len_q - LEN_BITS'(1));
    assign beats   = LEN_BITS'(ceil_div(int'(bias_len), N_LANES));

    bias_unpack #(
        .DIN_W   (DIN_W),
        .BIAS_W  (BIAS_W),
        .LEN_BITS(LEN_BITS)
    ) u_unpack (
        .clk         (clk),
        .reset       (reset),
        .load        (accept),
        .beats       (beats),
        .active      (state == LOAD),
        .flush       (last_wr),
        .fifo_data   (bus.fifo_data),
        .fifo_empty_n(bus.fifo_empty_n),
        .fifo_read   (bus.fifo_read),
        .lane_data   (lane_data),
        .lane_valid  (lane_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_n     = state;
        rd1st_start = 1'b0;
        busy        = (state != IDLE);
        done        = 1'b0;
        case (state)
            IDLE:    if (accept) state_n = LOAD;
            LOAD:    if (last_wr) state_n = WAIT_RD;
            WAIT_RD: begin
                rd1st_start = !started && !rd1st_busy;
                // started is still low in the pulse cycle, so a same-cycle done is ignored
                if (started && rd1st_done) state_n = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q   <= '0;
            wr_cnt  <= '0;
            started <= 1'b0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b1;
            err_len <= 1'b0;
        end else begin
            err_len <= (state == IDLE) && start && !len_ok;

            if (accept) begin
                len_q  <= bias_len;
                wr_cnt <= '0;
            end else if (wr_en && !last_wr) begin
                wr_cnt <= wr_cnt + (ADDR_BITS+1)'(1);
            end

            if (last_wr)
                rd_bank <= wr_bank;

            if (rd1st_start)
                started <= 1'b1;
            else if (state == DONE)
                started <= 1'b0;

            if (state == DONE)
                wr_bank <= ~wr_bank;
        end
    end

    always_comb begin
        bus.cen_bias  = 2'b11;
        bus.wen_bias  = 2'b11;
        bus.addr_bias = '0;
        bus.din_bias  = '0;
        for (int b = 0; b < 2; b++) begin
            if (wr_en && (wr_bank == 1'(b))) begin
                bus.cen_bias[b]                           = 1'b0;
                bus.wen_bias[b]                           = 1'b0;
                bus.addr_bias[b*ADDR_BITS +: ADDR_BITS]   = wr_cnt[ADDR_BITS-1:0];
                bus.din_bias[b*BIAS_W +: BIAS_W]          = lane_data;
            end
        end
    end

endmodule

// File: doc/biassram_wr_pp.md
Name: biassram_wr_pp

Overview:
Second-generation bias SRAM writer. Unpacks DIN_W-bit FIFO beats into BIAS_W-bit biases and writes them into one of two ping-pong bias SRAM banks. The bias count is set at run time per layer, so the next layer's bias can load while the other bank is read. It sits between the bias input FIFO and the two bias SRAM macros, and hands off to the bias first-read block (rd1st) after each load.

Parameters:
DIN_W, 64, FIFO data width; must be an integer multiple of BIAS_W.
BIAS_W, 32, bias word width; LANES = DIN_W/BIAS_W biases per beat.
ADDR_BITS, 9, per-bank SRAM address width; bank depth DEPTH = 2**ADDR_BITS.
LEN_BITS, 10, width of bias_len; must be at least ADDR_BITS+1.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to load one layer's bias
bias_len  in  LEN_BITS  number of biases for this layer; latched on an accepted start
fifo_data  in  DIN_W  FIFO head data (first-word-fall-through); lane 0 = bits [BIAS_W-1:0]
fifo_empty_n  in  1  FIFO head valid
fifo_read  out  1  pop request; a pop occurs when fifo_read & fifo_empty_n
cen_bias  out  2  per-bank chip enable, active low
wen_bias  out  2  per-bank write enable, active low
addr_bias  out  2*ADDR_BITS  bank b address at [b*ADDR_BITS +: ADDR_BITS]
din_bias  out  2*BIAS_W  bank b data at [b*BIAS_W +: BIAS_W]
wr_bank  out  1  bank currently being (or next to be) written
rd_bank  out  1  bank holding the most recently completed load
rd1st_start  out  1  one-cycle pulse that starts the first-read block
rd1st_busy  in  1  first-read block busy
rd1st_done  in  1  first-read block done pulse
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a layer load plus first read is complete
err_len  out  1  one-cycle pulse when start is rejected for an illegal length

Behaviour:
- Reset values:
  - state IDLE; fifo_read = 0; cen_bias = wen_bias = 2'b11; addr_bias = din_bias = 0.
  - wr_bank = 0, rd_bank = 1; rd1st_start = busy = done = err_len = 0.
  - Holding register invalid; all counters 0.
  - Reset mid-load abandons the load; partially written SRAM contents are don't-care.
- State machine: IDLE -> LOAD -> WAIT_RD -> DONE -> IDLE.
- IDLE:
  - start with 1 <= bias_len <= DEPTH: latch len, clear wr_cnt, go to LOAD.
  - start with bias_len = 0 or bias_len > DEPTH: err_len = 1 for the next cycle, stay in IDLE.
  - start while not in IDLE is ignored.
- LOAD datapath:
  - 64-bit holding register hold plus hold_valid and a lane index.
  - fifo_read is combinational: (state==LOAD) & beats_left != 0 & (!hold_valid | last lane of hold being written this cycle).
  - beats_left is initialised to ceil(len/LANES).
  - A pop loads hold, sets hold_valid, resets lane to 0 and decrements beats_left.
- Writes (in LOAD):
  - A write occurs in every cycle where hold_valid is high.
  - Bank wr_bank gets cen = wen = 0, addr = wr_cnt, din = hold lane slice.
  - The other bank's cen/wen stay 1.
  - Write signals are combinational from registered hold/lane/wr_cnt.
- Latency and throughput:
  - A beat popped in cycle t writes lane k in cycle t+1+k.
  - Sustained rate is one bias per cycle when the FIFO is never empty.
  - An empty FIFO inserts bubbles: no write, no counter change.
- Partial last beat: when wr_cnt reaches len-1 on a write, remaining lanes of hold are discarded, hold_valid clears, and the state goes to WAIT_RD.
- WAIT_RD:
  - rd_bank <= wr_bank on entry.
  - rd1st_start pulses for exactly one cycle, the first cycle in WAIT_RD with rd1st_busy = 0.
  - The state then waits for rd1st_done.
  - rd1st_done arriving in the same cycle as the start pulse is ignored.
- DONE: done = 1 for one cycle, wr_bank toggles, return to IDLE.
- Widths:
  - wr_cnt is ADDR_BITS+1 bits and never exceeds len-1.
  - No wrap: len = DEPTH writes addresses 0..DEPTH-1.

Decomposition:
- Shared package bias_pkg holds the state encoding (IDLE/LOAD/WAIT_RD/DONE), LANES, and the helper function ceil_div.
- One natural sub-module, bias_unpack: holding register, lane index, fifo_read/pop logic; it outputs lane data plus a valid strobe.
- The top level keeps the FSM, counters, bank muxing and the rd1st handshake.

Test Plan:
1. len=64, FIFO preloaded with 32 beats → 64 writes on bank 0 in consecutive cycles; addresses 0..63; din = lane0, lane1 of each beat; rd1st_start one pulse; done after rd1st_done; wr_bank becomes 1.
2. len=5, 3 beats → exactly 5 writes; the upper lane of beat 3 is never written; exactly 3 pops.
3. fifo_empty_n toggling 1/0 every cycle, len=8 → still exactly 8 writes in address order; no write in bubble cycles; no pop while empty.
4. Two back-to-back layers of len=4 → layer 1 writes bank 0 and rd_bank=0; layer 2 writes bank 1 and rd_bank=1; bank 0 cen stays 1 during layer 2.
5. start with bias_len=0 and then bias_len=513 → err_len pulses each time; busy stays 0; no fifo_read; no writes.
6. Reset asserted mid-LOAD at wr_cnt=10 → next cycle all outputs at reset values and wr_bank=0; a subsequent start with len=2 performs a normal load.
